// File: rtl/procb_rd.sv
// procb record-buffer reader: walks one thread's records and emits <=8-byte read chunks.
// Optional feature macro: PROCB_RD_ALIGN_EN (chunks never cross an 8-byte boundary).
`ifndef PROCB_ADDR_WIDTH
`define PROCB_ADDR_WIDTH 32
`endif
`ifndef PROCB_CNT_WIDTH
`define PROCB_CNT_WIDTH 16
`endif
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH (`PROCB_ADDR_WIDTH + `PROCB_CNT_WIDTH + 2)
`endif
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

module procb_rd #(
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = `MSB(N_THREADS - 1)
) (
  input  logic                          CLK,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_THREADS_MSB:0]        start_thread_num,
  output logic                          busy,
  output logic                          done,
  output logic                          done_fin,
  output logic                          done_stop,
  output logic                          done_err,
  output logic [N_THREADS_MSB:0]        rd_thread_num,
  output logic                          rd_en,
  output logic                          lookup_en,
  output logic                          rd_rst,
  input  logic                          lookup_empty,
  input  logic [`PROCB_D_WIDTH-1:0]     din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [`PROCB_ADDR_WIDTH-1:0]  out_addr,
  output logic [3:0]                    out_bytes,
  output logic                          out_last,
  output logic [3:0]                    dbg_state
);

  localparam int AW = `PROCB_ADDR_WIDTH;
  localparam int CW = `PROCB_CNT_WIDTH;

  // Handshake: a chunk transfers on a rising CLK edge where out_valid and out_ready
  // are both high; while out_valid is high and out_ready low, out_addr/out_bytes/out_last hold.

  typedef enum logic [3:0] {
    S_IDLE, S_W1, S_W2, S_CHECK, S_RUN, S_CONSUME, S_NEXT, S_ABORT, S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] cur_addr;
  logic [CW-1:0] rem;
  logic          fin_r, stop_r, err_r;

  logic [AW-1:0] rec_addr;
  logic [CW-1:0] rec_cnt;
  logic          rec_fin, rec_stop;
  assign {rec_stop, rec_fin, rec_cnt, rec_addr} = din;

  logic [3:0]    lim;
  logic [3:0]    n;
  logic [CW-1:0] n_cw;
  logic          last_chunk;

`ifdef PROCB_RD_ALIGN_EN
  assign lim = 4'd8 - {1'b0, cur_addr[2:0]};
`else
  assign lim = 4'd8;
`endif
  assign n          = (rem < {{(CW-4){1'b0}}, lim}) ? rem[3:0] : lim;
  assign n_cw       = {{(CW-4){1'b0}}, n};
  assign last_chunk = (n_cw == rem);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rd_thread_num <= '0;
      cur_addr      <= '0;
      rem           <= '0;
      fin_r         <= 1'b0;
      stop_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          rd_thread_num <= start_thread_num;
          fin_r         <= 1'b0;
          stop_r        <= 1'b0;
          err_r         <= 1'b0;
        end
        S_CHECK: if (!lookup_empty) begin
          cur_addr <= rec_addr;
          rem      <= rec_cnt;
          fin_r    <= rec_fin;
          stop_r   <= rec_stop;
        end
        S_RUN: if (out_ready) begin
          cur_addr <= cur_addr + {{(AW-4){1'b0}}, n};
          rem      <= rem - n_cw;
        end
        S_ABORT: begin
          err_r  <= 1'b1;
          fin_r  <= 1'b0;
          stop_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = 1'b0;
    done_fin  = 1'b0;
    done_stop = 1'b0;
    done_err  = 1'b0;
    rd_en     = 1'b0;
    lookup_en = 1'b0;
    rd_rst    = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_bytes = 4'd0;
    out_last  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_W1;
      S_W1:    state_nx = S_W2;
      S_W2:    state_nx = S_CHECK;
      S_CHECK: begin
        if (lookup_empty)       state_nx = S_ABORT;
        else if (rec_cnt == '0) state_nx = S_CONSUME;
        else                    state_nx = S_RUN;
      end
      S_RUN: begin
        out_valid = 1'b1;
        out_addr  = cur_addr;
        out_bytes = n;
        out_last  = last_chunk && fin_r;
        if (out_ready && last_chunk) state_nx = S_CONSUME;
      end
      S_CONSUME: begin
        rd_en     = 1'b1;
        lookup_en = 1'b1;
        rd_rst    = fin_r || stop_r;
        state_nx  = (fin_r || stop_r) ? S_DONE : S_NEXT;
      end
      S_NEXT:  state_nx = S_CHECK;
      // Empty buffer before a terminal record: reset the thread's read side.
      S_ABORT: begin
        rd_en    = 1'b1;
        rd_rst   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        done_fin  = fin_r;
        done_stop = stop_r;
        done_err  = err_r;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign dbg_state = state;

endmodule
